// File: rtl/soc_riscv_cpu2ahb_bridge.sv
// soc_riscv_cpu2ahb_bridge
// Single-outstanding bridge from the RISC-V CPU data-memory port to an AHB-Lite master.
// Byte enables are decoded into HSIZE; misaligned requests are rejected without a bus cycle.
module soc_riscv_cpu2ahb_bridge #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PHYS_ADDR_SIZE = XLEN
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [XLEN-1:0]           mem_adr,
    input  logic [XLEN-1:0]           mem_d,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [XLEN/8-1:0]         mem_be,
    output logic [XLEN-1:0]           mem_q,
    output logic                      mem_ack,
    output logic                      mem_err,
    output logic                      mem_misaligned,
    output logic                      HSEL,
    output logic [PHYS_ADDR_SIZE-1:0] HADDR,
    output logic [XLEN-1:0]           HWDATA,
    input  logic [XLEN-1:0]           HRDATA,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [1:0]                HTRANS,
    output logic                      HMASTLOCK,
    input  logic                      HREADY,
    input  logic                      HRESP
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned LW    = $clog2(LANES);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   adr_q;
    logic [XLEN-1:0]   d_q;
    logic              we_q;
    logic              mis_q;
    logic [2:0]        size_q;

    // Request decode
    int unsigned       be_cnt;
    logic [LW-1:0]     be_low;
    logic [LANES-1:0]  be_norm;
    logic [2:0]        req_size;
    logic              req_mis;

    // Completion strobes, registered into the one-cycle CPU pulses
    logic              ack_set;
    logic              err_set;
    logic              mis_set;

    // Size and misalignment decode of the incoming byte enables
    always_comb begin
        be_cnt   = 0;
        be_low   = '0;
        req_size = 3'd0;
        req_mis  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            be_cnt = be_cnt + 32'(mem_be[i]);
            if (mem_be[i]) begin
                be_low = LW'(i);
            end
        end
        // Shifting the lowest lane down to bit 0 makes a contiguous run look like 2^k-1
        be_norm = mem_be >> be_low;

        if (be_cnt == 1) begin
            req_size = 3'd0;
        end else if (be_cnt == 2) begin
            req_size = 3'd1;
        end else if (be_cnt == 4) begin
            req_size = 3'd2;
        end else if (XLEN == 64 && be_cnt == 8) begin
            req_size = 3'd3;
        end else begin
            // Also covers be == 0
            req_mis = 1'b1;
        end

        if (((be_norm + LANES'(1)) & be_norm) != '0) begin
            req_mis = 1'b1;
        end
        if (be_low != mem_adr[LW-1:0]) begin
            req_mis = 1'b1;
        end
        case (req_size)
            3'd1:    if (mem_adr[0])      req_mis = 1'b1;
            3'd2:    if (|mem_adr[1:0])   req_mis = 1'b1;
            3'd3:    if (|mem_adr[2:0])   req_mis = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (mem_req) state_d = StAddr;
            end
            StAddr: begin
                // A rejected request spends its single ADDR cycle with HTRANS left IDLE
                if (mis_q) begin
                    state_d = StIdle;
                end else if (HREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (HRESP) begin
                    state_d = HREADY ? StIdle : StErr;
                end else if (HREADY) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                if (HREADY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs and completion strobes
    always_comb begin
        HSEL      = (state_q == StAddr) && !mis_q;
        HTRANS    = HSEL ? 2'b10 : 2'b00;
        HADDR     = adr_q[PHYS_ADDR_SIZE-1:0];
        HWRITE    = we_q;
        HSIZE     = size_q;
        HWDATA    = '0;
        if ((state_q == StData || state_q == StErr) && we_q) begin
            HWDATA = d_q;
        end
        HBURST    = 3'b000;
        HPROT     = 4'b0011;
        HMASTLOCK = 1'b0;

        ack_set = (state_q == StData) && HREADY && !HRESP;
        err_set = ((state_q == StErr) && HREADY) || ((state_q == StData) && HREADY && HRESP);
        mis_set = (state_q == StIdle) && mem_req && req_mis;
    end

    // Request capture, read-data capture and CPU response pulses
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            adr_q          <= '0;
            d_q            <= '0;
            we_q           <= 1'b0;
            mis_q          <= 1'b0;
            size_q         <= 3'd0;
            mem_q          <= '0;
            mem_ack        <= 1'b0;
            mem_err        <= 1'b0;
            mem_misaligned <= 1'b0;
        end else begin
            mem_ack        <= ack_set;
            mem_err        <= err_set;
            mem_misaligned <= mis_set;
            if (state_q == StIdle && mem_req) begin
                adr_q  <= mem_adr;
                d_q    <= mem_d;
                we_q   <= mem_we;
                mis_q  <= req_mis;
                size_q <= req_size;
            end
            if (ack_set && !we_q) begin
                mem_q <= HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_soc_riscv_cpu2ahb_bridge.sv
// Scoreboard bench for soc_riscv_cpu2ahb_bridge: a driver issues CPU requests and plays the
// AHB slave, pushing expected bus and CPU responses; a negedge monitor pops and compares.
module tb_soc_riscv_cpu2ahb_bridge;
    localparam int KACK = 0;
    localparam int KERR = 1;
    localparam int KMIS = 2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] mem_adr = '0;
    logic [31:0] mem_d = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_be = '0;
    logic [31:0] mem_q;
    logic        mem_ack;
    logic        mem_err;
    logic        mem_misaligned;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    soc_riscv_cpu2ahb_bridge #(.XLEN(32), .PHYS_ADDR_SIZE(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .mem_adr(mem_adr), .mem_d(mem_d), .mem_req(mem_req),
        .mem_we(mem_we), .mem_be(mem_be), .mem_q(mem_q), .mem_ack(mem_ack), .mem_err(mem_err),
        .mem_misaligned(mem_misaligned), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [31:0] q;
        int unsigned cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
        logic [31:0] wdata;
    } ahb_t;

    rsp_t        rsp_q[$];
    ahb_t        ahb_q[$];
    logic [31:0] model_q = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: legal iff be is a run of n in {1,2,4} lanes starting at adr%4, adr aligned to n
    function automatic bit ref_legal(input logic [31:0] adr, input logic [3:0] be,
                                     output logic [2:0] size);
        int o;
        o = int'(adr[1:0]);
        size = 3'd0;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 1 << k;
            if ((o % n) == 0 && int'(be) == (((1 << n) - 1) << o)) begin
                size = 3'(k);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Monitor: compares everything the DUT presents against the scoreboard queues
    logic data_act = 1'b0;
    ahb_t data_e;
    always @(negedge HCLK) begin
        int   npulse;
        int   kind;
        rsp_t e;
        ahb_t a;
        if (HRESET) begin
            data_act = 1'b0;
        end else begin
            chk("hburst", 32'(HBURST), 32'd0);
            chk("hprot", 32'(HPROT), 32'd3);
            chk("hmastlock", 32'(HMASTLOCK), 32'd0);
            chk("hsel_vs_htrans", 32'(HSEL), 32'(HTRANS == 2'b10));
            if (HTRANS != 2'b00 && HTRANS != 2'b10) chk("htrans_legal", 32'(HTRANS), 32'd0);

            if (data_act) begin
                if (!HRESP) chk("hwdata", HWDATA, data_e.wdata);
                if (HREADY) data_act = 1'b0;
            end

            if (HTRANS == 2'b10) begin
                if (ahb_q.size() == 0) begin
                    chk("unexpected_nonseq_haddr", HADDR, 32'hxxxx_xxxx);
                end else begin
                    a = ahb_q[0];
                    chk("haddr", HADDR, a.addr);
                    chk("hwrite", 32'(HWRITE), 32'(a.we));
                    chk("hsize", 32'(HSIZE), 32'(a.size));
                    if (HREADY) begin
                        void'(ahb_q.pop_front());
                        data_e   = a;
                        data_act = 1'b1;
                    end
                end
            end

            npulse = int'(mem_ack) + int'(mem_err) + int'(mem_misaligned);
            if (npulse != 0) begin
                chk("pulse_onehot", 32'(npulse), 32'd1);
                kind = mem_ack ? KACK : (mem_err ? KERR : KMIS);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_pulse_kind", 32'(kind), 32'hffff_ffff);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_kind", 32'(kind), 32'(e.kind));
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("mem_q", mem_q, e.q);
                end
            end
        end
    end

    // One CPU request plus the AHB slave behaviour for it; called at posedge+1
    task automatic do_txn(input logic [31:0] adr, input logic [3:0] be, input logic we,
                          input logic [31:0] d, input logic [31:0] rdata, input int aw,
                          input int dw, input bit er, input bit junk);
        int unsigned n;
        logic [2:0]  size;
        bit          legal;
        rsp_t        r;
        ahb_t        a;
        n = cyc;
        legal = ref_legal(adr, be, size);
        if (!legal) begin
            r = '{kind: KMIS, q: model_q, cyc: n + 1};
            rsp_q.push_back(r);
        end else begin
            a = '{addr: adr, we: we, size: size, wdata: we ? d : 32'h0};
            ahb_q.push_back(a);
            if (er) begin
                r = '{kind: KERR, q: model_q, cyc: n + 4 + aw};
            end else begin
                if (!we) model_q = rdata;
                r = '{kind: KACK, q: model_q, cyc: n + 3 + aw + dw};
            end
            rsp_q.push_back(r);
        end

        mem_req = 1'b1; mem_adr = adr; mem_be = be; mem_we = we; mem_d = d;
        HREADY = 1'($urandom); HRESP = 1'b0;
        @(posedge HCLK) #1;
        mem_req = 1'b0; mem_adr = $urandom; mem_d = $urandom;
        mem_be = 4'($urandom); mem_we = 1'($urandom);

        if (legal) begin
            repeat (aw) begin
                HREADY = 1'b0; HRDATA = $urandom;
                @(posedge HCLK) #1;
            end
            HREADY = 1'b1;
            @(posedge HCLK) #1;
            if (!er) begin
                repeat (dw) begin
                    HREADY = 1'b0; HRDATA = $urandom; mem_req = junk;
                    @(posedge HCLK) #1;
                    mem_req = 1'b0;
                end
                HREADY = 1'b1; HRDATA = rdata;
                @(posedge HCLK) #1;
            end else begin
                HREADY = 1'b0; HRESP = 1'b1; HRDATA = $urandom;
                @(posedge HCLK) #1;
                HREADY = 1'b1; HRESP = 1'b1;
                @(posedge HCLK) #1;
                HRESP = 1'b0;
            end
            HRDATA = $urandom;
        end
        @(posedge HCLK) #1;
    endtask

    // Write interrupted by reset in its data phase, with a request offered in the reset cycle
    task automatic reset_in_data();
        ahb_t a;
        a = '{addr: 32'h0000_0400, we: 1'b1, size: 3'd2, wdata: 32'hCAFE_F00D};
        ahb_q.push_back(a);
        mem_req = 1'b1; mem_adr = 32'h400; mem_be = 4'hF; mem_we = 1'b1; mem_d = 32'hCAFE_F00D;
        @(posedge HCLK) #1;
        mem_req = 1'b0; HREADY = 1'b1;
        @(posedge HCLK) #1;
        HREADY = 1'b0; HRESET = 1'b1;
        mem_req = 1'b1; mem_adr = 32'h500; mem_be = 4'hF; mem_we = 1'b0;
        @(posedge HCLK) #1;
        HRESET = 1'b0; mem_req = 1'b0; HREADY = 1'b1;
        model_q = '0;
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_hsel", 32'(HSEL), 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_mem_q", mem_q, 32'd0);
        chk("rst_pulses", {29'd0, mem_ack, mem_err, mem_misaligned}, 32'd0);
        @(posedge HCLK) #1;
        chk("rst_req_ignored_htrans", 32'(HTRANS), 32'd0);
    endtask

    initial begin
        logic [31:0] adr;
        logic [3:0]  be;
        int          nb;
        int          off;
        repeat (3) @(posedge HCLK);
        #1;
        chk("init_htrans", 32'(HTRANS), 32'd0);
        chk("init_hsel", 32'(HSEL), 32'd0);
        chk("init_haddr", HADDR, 32'd0);
        chk("init_hwdata", HWDATA, 32'd0);
        chk("init_mem_q", mem_q, 32'd0);
        chk("init_pulses", {29'd0, mem_ack, mem_err, mem_misaligned}, 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK) #1;

        do_txn(32'h100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0);
        do_txn(32'h203, 4'b1000, 1'b0, 32'h0, 32'h5A00_0000, 0, 0, 1'b0, 1'b0);
        do_txn(32'h101, 4'b0110, 1'b0, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        do_txn(32'h108, 4'b1111, 1'b1, 32'h1357_9BDF, 32'h0, 2, 3, 1'b0, 1'b1);
        do_txn(32'h10C, 4'b1111, 1'b0, 32'h0, 32'h0BAD_0BAD, 0, 0, 1'b1, 1'b0);
        do_txn(32'h10A, 4'b1100, 1'b0, 32'h0, 32'h7777_0000, 1, 1, 1'b0, 1'b0);
        reset_in_data();
        do_txn(32'h600, 4'b1111, 1'b0, 32'h0, 32'h600D_600D, 0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                nb  = 1 << $urandom_range(0, 2);
                off = $urandom_range(0, 4 - nb);
                off = (off / nb) * nb;
                be  = 4'(((1 << nb) - 1) << off);
                adr = ($urandom & 32'hFFFF_FFFC) | 32'(off);
            end else begin
                be  = 4'($urandom_range(0, 15));
                adr = $urandom;
            end
            do_txn(adr, be, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'($urandom));
        end

        repeat (5) @(posedge HCLK);
        #1;
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("ahb_queue_drained", 32'(ahb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_riscv_cpu2ahb_bridge.md
# soc_riscv_cpu2ahb_bridge

Single-outstanding bridge converting the RISC-V CPU data-memory request interface into AHB-Lite master transfers. It sits between the CPU load/store unit and the AHB-Lite interconnect. It decodes byte enables into HSIZE, rejects misaligned requests without issuing a bus cycle, and returns read data, acknowledge or error to the CPU. Its AHB outputs are the signals monitored by the cpu2ahb checker.

## Interface
- XLEN, 32, data width; XLEN/8 byte lanes; legal values 32 and 64.
- PHYS_ADDR_SIZE, XLEN, HADDR width; HADDR = mem_adr[PHYS_ADDR_SIZE-1:0].

Ports:
- HCLK  in  1  sole clock, all logic on posedge.
- HRESET  in  1  synchronous, active-high reset.
- mem_adr  in  XLEN  byte address.
- mem_d  in  XLEN  write data.
- mem_req  in  1  one-cycle request pulse; CPU issues the next only after mem_ack, mem_err or mem_misaligned.
- mem_we  in  1  1 = write.
- mem_be  in  XLEN/8  byte enables.
- mem_q  out  XLEN  read data, valid with mem_ack on reads.
- mem_ack  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle bus-error pulse.
- mem_misaligned  out  1  one-cycle reject pulse, cycle after mem_req.
- HSEL  out  1  high during the address phase.
- HADDR  out  PHYS_ADDR_SIZE  transfer address.
- HWDATA  out  XLEN  write data, driven in the data phase.
- HRDATA  in  XLEN  read data.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  0 byte, 1 half, 2 word, 3 dword.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011 (data, privileged, non-bufferable, non-cacheable).
- HTRANS  out  2  IDLE(00) or NONSEQ(10) only.
- HMASTLOCK  out  1  constant 0.
- HREADY  in  1  transfer-done / slave ready.
- HRESP  in  1  1 = ERROR.

## Operation
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE: if mem_req is high, register adr/we/be/d, compute size and misalignment, go to ADDR. If misaligned, the next cycle emits a mem_misaligned pulse, HTRANS stays IDLE, and the FSM returns to IDLE.
- Size decode: popcount(be) ∈ {1,2,4,8 (XLEN=64 only)}, ones contiguous, HSIZE = log2(popcount).
- Misaligned if any of the following holds:
  - be == 0;
  - popcount is illegal;
  - ones are non-contiguous;
  - lowest set lane ≠ adr[log2(XLEN/8)-1:0];
  - adr is not a multiple of 2^HSIZE.
- ADDR: drive HSEL=1, HTRANS=NONSEQ, HADDR, HWRITE, HSIZE. Hold all of these stable while HREADY=0. On an edge with HREADY=1, go to DATA.
- DATA: HTRANS=IDLE, HSEL=0; HWDATA = registered d (writes; held 0 on reads).
  - Edge with HREADY=1 and HRESP=0: next cycle pulse mem_ack; on reads mem_q = captured HRDATA. Go to IDLE.
  - HRESP=1 with HREADY=0 (first error cycle): go to ERR.
- ERR: wait for HREADY=1 (second error cycle), then pulse mem_err next cycle and go to IDLE. mem_q is unchanged.
- Exactly one NONSEQ is issued per accepted aligned request; none for misaligned requests.
- mem_req while not IDLE is a protocol violation: it is ignored and no transfer is issued.

## Timing
- Reset values:
  - state = IDLE;
  - HTRANS = 00, HSEL = 0, HWRITE = 0, HADDR = 0, HWDATA = 0, HSIZE = 0;
  - mem_q = 0, mem_ack = 0, mem_err = 0, mem_misaligned = 0.
- Constant outputs (HBURST, HPROT, HMASTLOCK) are independent of reset.
- Cycle n: mem_req sampled. Cycle n+1: address phase (or mem_misaligned pulse). Data phase begins at the first HREADY=1 edge of the address phase.
- Zero-wait-state read or write: mem_ack is high in cycle n+3. Each HREADY=0 cycle in either phase adds one cycle.
- Minimum request-to-request spacing: 4 cycles (aligned), 2 cycles (misaligned).
- mem_ack, mem_err and mem_misaligned are registered, mutually exclusive, and each lasts exactly one cycle.
- HRESET asserted in any state:
  - next edge forces IDLE and HTRANS=IDLE;
  - the pending transaction is dropped with no ack, err or misaligned pulse;
  - mem_req in the reset cycle is ignored.

## Test plan
- Aligned word write: adr=0x100, be=1111, d=0xDEADBEEF, HREADY=1. Expect:
  - NONSEQ in cycle n+1 with HADDR=0x100, HWRITE=1, HSIZE=2;
  - HWDATA=0xDEADBEEF in n+2;
  - mem_ack in n+3.
- Byte read: adr=0x203, be=1000, HRDATA=0x5A000000. Expect HSIZE=0, HADDR=0x203, mem_q=0x5A000000 with mem_ack.
- Misaligned half: adr=0x101, be=0110. Expect mem_misaligned pulse in n+1, HTRANS stays IDLE throughout, no mem_ack.
- Wait states: HREADY=0 for 2 cycles in the address phase and 3 cycles in the data phase. Expect HADDR/HTRANS stable while stalled, HWDATA stable, mem_ack in n+8.
- Error response: two-cycle HRESP=1 (HREADY=0 then 1). Expect mem_err one cycle after the second error cycle, no mem_ack, mem_q unchanged.
- Reset asserted during DATA of a write. Expect HTRANS=IDLE and all outputs at reset values after the next edge, no completion pulse, and a new request accepted normally afterwards.
